button_event_gen: RTL and testbench
===================================

Name: button_event_gen

Overview:
- Consumer end of the debounced-button path. Takes a clean debounced level and turns it into discrete game events: a press, auto-repeat while held, and a release pulse.
- Presents events to frame-rate game logic through a one-deep valid/ack slot, so a slow consumer never misses a press silently.
- Sits between the button debouncer and the bird-control / game-state logic.

Parameters:
- HOLD_LIMIT, 12_500_000: cycles the button must stay held after a press before the first repeat event. 0.5 s at 25 MHz. Must be >= 2.
- REPEAT_LIMIT, 2_500_000: cycles between successive repeat events. 100 ms at 25 MHz. Must be >= 2.
- ENABLE_REPEAT, 1: 1 enables auto-repeat; 0 means one event per press.

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  synchronous, active-high reset
- i_Debounced  in  1  debounced button level, 1 = pressed
- i_Event_Ack  in  1  consumer accepts the pending event
- o_Event_Valid  out  1  an event is pending in the slot
- o_Event_Is_Repeat  out  1  pending event payload: 0 = initial press, 1 = auto-repeat
- o_Held  out  1  button currently tracked as held
- o_Release_Pulse  out  1  one-cycle pulse on release
- o_Drop_Count  out  8  saturating count of events lost because the slot was full

Behaviour:
- Reset (synchronous, i_Rst = 1 at a clock edge):
  - State = IDLE, counter = 0.
  - o_Event_Valid, o_Event_Is_Repeat, o_Release_Pulse, o_Held = 0; o_Drop_Count = 0.
  - Previous-level register r_Prev = 1, so a button held through reset produces no event until it is released and pressed again.
  - Reset mid-operation discards any pending event and in-progress hold count.
- Edge detect: rise = i_Debounced & ~r_Prev. r_Prev <= i_Debounced every cycle.
- FSM states: IDLE, HOLD, REPEAT.
  - IDLE: on rise -> HOLD, counter <= 0, generate press event (Is_Repeat = 0). Level-high without a rise stays IDLE.
  - HOLD:
    - If i_Debounced = 0 -> IDLE, o_Release_Pulse for one cycle.
    - Else if counter == HOLD_LIMIT-1 and ENABLE_REPEAT -> REPEAT, counter <= 0, generate repeat event.
    - Else counter increments, saturating at HOLD_LIMIT-1 when ENABLE_REPEAT = 0.
  - REPEAT:
    - If i_Debounced = 0 -> IDLE, release pulse.
    - Else if counter == REPEAT_LIMIT-1 -> generate repeat event, counter <= 0.
    - Else counter increments.
  - Release has priority over a limit hit in the same cycle: no event is generated.
- o_Held = (state != IDLE), registered.
- Latency: the event is registered on the same edge as the IDLE->HOLD transition, so o_Event_Valid is high one cycle after i_Debounced is first sampled high.
- Counter width: $clog2 of the larger of HOLD_LIMIT and REPEAT_LIMIT.
- Event slot handshake:
  - o_Event_Valid stays high until a clock edge with Valid & Ack; it clears after that edge.
  - Payload is stable while Valid = 1 and not acked.
  - New event in the same cycle as Valid & Ack: Valid stays 1, payload is replaced, no drop.
  - New event while Valid = 1 and not acked: event discarded, payload unchanged, o_Drop_Count += 1, saturating at 255.
  - Ack while Valid = 0 is ignored.
  - New event while Valid = 0 loads the slot.
- Release and press-event generation cannot coincide (a release exits to IDLE; a rise needs the previous cycle low).

Decomposition:
- Package button_event_pkg: state enum t_Btn_State {IDLE, HOLD, REPEAT}, and constant DROP_COUNT_WIDTH = 8.
- Sub-module event_slot: one-deep valid/ack register with 1-bit payload and saturating drop counter. Reusable for other game events.
- The FSM and counter stay in the top module.

Test Plan:
All scenarios use HOLD_LIMIT = 8, REPEAT_LIMIT = 4, ENABLE_REPEAT = 1 unless stated; t0 is the edge where HOLD is entered.
1. Press held 3 cycles, ack on the first Valid cycle -> exactly one event with Is_Repeat = 0; o_Release_Pulse for one cycle 3 cycles after t0; o_Held back to 0; o_Drop_Count = 0.
2. Hold 18 cycles, ack every Valid cycle -> 4 events at t0, t0+8, t0+12, t0+16 with Is_Repeat = 0, 1, 1, 1; then one release pulse.
3. Same 18-cycle hold, never ack -> Valid latched with Is_Repeat = 0; o_Drop_Count = 3; payload never changes.
4. i_Debounced = 1 throughout reset, then held 10 cycles -> no event. Release, then press again -> press event one cycle after the rise.
5. Release at t0+8, coinciding with counter == 7 -> no repeat event; release pulse occurs; state returns to IDLE.
6. Slot holds the press event; ack asserted on the same edge the t0+8 repeat is generated -> Valid stays 1, Is_Repeat becomes 1, o_Drop_Count = 0. With ENABLE_REPEAT = 0 and a 30-cycle hold -> exactly one event.

Source files
------------

// File: rtl/button_event_pkg.sv
// Shared types and constants for the button event path.
package button_event_pkg;

    // Tracking state of the debounced button.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } t_Btn_State;

    // Width of the saturating lost-event counter.
    localparam int DROP_COUNT_WIDTH = 8;

    // Larger of two integers, used to size the shared hold/repeat counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/event_slot.sv
// One-deep valid/ack event register with a 1-bit payload and a saturating
// count of events that arrived while the slot was occupied.
module event_slot
    import button_event_pkg::*;
(
    input  logic                        i_Clk,
    input  logic                        i_Rst,
    input  logic                        i_Push,
    input  logic                        i_Push_Data,
    input  logic                        i_Ack,
    output logic                        o_Valid,
    output logic                        o_Data,
    output logic [DROP_COUNT_WIDTH-1:0] o_Drop_Count
);

    logic                        valid_q, valid_d;
    logic                        data_q,  data_d;
    logic [DROP_COUNT_WIDTH-1:0] drop_q,  drop_d;
    logic                        take;

    // An ack only counts while an event is actually pending.
    assign take = valid_q & i_Ack;

    // Next-state for the slot: load, replace-on-ack, drop, or clear.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        data_d  = data_q;
        drop_d  = drop_q;
        if (i_Push) begin
            if (!valid_q || take) begin
                // Empty slot, or consumer emptying it this very edge: load the new event.
                valid_d = 1'b1;
                data_d  = i_Push_Data;
            end else if (drop_q != {DROP_COUNT_WIDTH{1'b1}}) begin
                // Slot full and not acked: keep the pending event, record the loss.
                drop_d = drop_q + DROP_COUNT_WIDTH'(1);
            end
        end else if (take) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers with synchronous reset.
    always_ff @(posedge i_Clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (i_Rst) begin
            valid_q <= 1'b0;
            data_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign o_Valid      = valid_q;
    assign o_Data       = data_q;
    assign o_Drop_Count = drop_q;

endmodule

// File: rtl/button_event_gen.sv
// Turns a debounced button level into press / auto-repeat events delivered
// through a one-deep valid/ack slot, plus a one-cycle release pulse.
module button_event_gen
    import button_event_pkg::*;
#(
    parameter int HOLD_LIMIT    = 12_500_000,
    parameter int REPEAT_LIMIT  = 2_500_000,
    parameter int ENABLE_REPEAT = 1
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst,
    input  logic                        i_Debounced,
    input  logic                        i_Event_Ack,
    output logic                        o_Event_Valid,
    output logic                        o_Event_Is_Repeat,
    output logic                        o_Held,
    output logic                        o_Release_Pulse,
    output logic [DROP_COUNT_WIDTH-1:0] o_Drop_Count
);

    localparam int CNT_W = $clog2(max_int(HOLD_LIMIT, REPEAT_LIMIT));
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_LIMIT - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_LIMIT - 1);

    t_Btn_State       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             prev_q;
    logic             release_q, release_d;
    logic             rise;
    logic             push;
    logic             push_is_repeat;

    // Press is a low-to-high transition; prev resets high so a button held
    // through reset must be released before it can generate a press.
    assign rise = i_Debounced & ~prev_q;

    // Next-state, counter and event generation for the hold/repeat tracker.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        push           = 1'b0;
        push_is_repeat = 1'b0;
        release_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HOLD;
                    count_d = '0;
                    push    = 1'b1;
                end
            end
            HOLD: begin
                // Release wins over a limit hit on the same cycle.
                if (!i_Debounced) begin
                    state_d   = IDLE;
                    count_d   = '0;
                    release_d = 1'b1;
                end else if (count_q == HOLD_LAST) begin
                    if (ENABLE_REPEAT != 0) begin
                        state_d        = REPEAT;
                        count_d        = '0;
                        push           = 1'b1;
                        push_is_repeat = 1'b1;
                    end
                    // Without repeat the counter parks at the limit until release.
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (!i_Debounced) begin
                    state_d   = IDLE;
                    count_d   = '0;
                    release_d = 1'b1;
                end else if (count_q == REPEAT_LAST) begin
                    count_d        = '0;
                    push           = 1'b1;
                    push_is_repeat = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // Tracker registers with synchronous reset; a reset abandons any hold count.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            prev_q    <= 1'b1;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            prev_q    <= i_Debounced;
            release_q <= release_d;
        end
    end

    assign o_Held          = (state_q != IDLE);
    assign o_Release_Pulse = release_q;

    event_slot u_slot (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .i_Push       (push),
        .i_Push_Data  (push_is_repeat),
        .i_Ack        (i_Event_Ack),
        .o_Valid      (o_Event_Valid),
        .o_Data       (o_Event_Is_Repeat),
        .o_Drop_Count (o_Drop_Count)
    );

endmodule

// File: tb/tb_button_event_gen.sv
// Directed self-checking bench for button_event_gen (HOLD_LIMIT=8, REPEAT_LIMIT=4).
module tb_button_event_gen;

    logic       clk;
    logic       rst;
    logic       deb;
    logic       ack;

    logic       valid, rep, held, rel;
    logic [7:0] drop;
    logic       nr_valid, nr_rep, nr_held, nr_rel;
    logic [7:0] nr_drop;

    int checks   = 0;
    int failures = 0;

    button_event_gen #(.HOLD_LIMIT(8), .REPEAT_LIMIT(4), .ENABLE_REPEAT(1)) dut (
        .i_Clk             (clk),
        .i_Rst             (rst),
        .i_Debounced       (deb),
        .i_Event_Ack       (ack),
        .o_Event_Valid     (valid),
        .o_Event_Is_Repeat (rep),
        .o_Held            (held),
        .o_Release_Pulse   (rel),
        .o_Drop_Count      (drop)
    );

    button_event_gen #(.HOLD_LIMIT(8), .REPEAT_LIMIT(4), .ENABLE_REPEAT(0)) dut_nr (
        .i_Clk             (clk),
        .i_Rst             (rst),
        .i_Debounced       (deb),
        .i_Event_Ack       (ack),
        .o_Event_Valid     (nr_valid),
        .o_Event_Is_Repeat (nr_rep),
        .o_Held            (nr_held),
        .o_Release_Pulse   (nr_rel),
        .o_Drop_Count      (nr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       deb;
        logic       ack;
        logic       valid;
        logic       rep;
        logic       held;
        logic       rel;
        logic [7:0] drop;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic level);
        rst = 1'b1;
        deb = level;
        ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int ev_k[$];
    logic ev_r[$];
    int exp_k[4] = '{0, 8, 12, 16};
    logic exp_r[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    int bad;
    int n_rel;
    int n_ev;

    initial begin
        rst = 1'b1;
        deb = 1'b0;
        ack = 1'b0;

        // Reset state.
        do_reset(1'b0);
        check("reset_valid", valid, 0);
        check("reset_rep",   rep,   0);
        check("reset_held",  held,  0);
        check("reset_rel",   rel,   0);
        check("reset_drop",  drop,  0);

        // Short press (3 cycles, acked at once) then release at counter == 7.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        for (int i = 8; i < 14; i++)
            vecs[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

        for (int i = 0; i < 16; i++) begin
            deb = vecs[i].deb;
            ack = vecs[i].ack;
            tick();
            check($sformatf("vec%0d_valid", i), valid, vecs[i].valid);
            check($sformatf("vec%0d_rep",   i), rep,   vecs[i].rep);
            check($sformatf("vec%0d_held",  i), held,  vecs[i].held);
            check($sformatf("vec%0d_rel",   i), rel,   vecs[i].rel);
            check($sformatf("vec%0d_drop",  i), drop,  vecs[i].drop);
        end
        ack = 1'b0;

        // 18-cycle hold, ack every valid cycle: events at k = 0, 8, 12, 16.
        do_reset(1'b0);
        tick();
        n_rel = 0;
        for (int k = 0; k < 20; k++) begin
            deb = (k < 18);
            ack = valid;
            tick();
            if (valid) begin
                ev_k.push_back(k);
                ev_r.push_back(rep);
            end
            if (rel) n_rel++;
            if (k == 18) check("hold18_release_pulse", rel, 1);
        end
        ack = 1'b0;
        check("hold18_event_count", ev_k.size(), 4);
        for (int j = 0; j < 4; j++) begin
            if (j < ev_k.size()) begin
                check($sformatf("hold18_ev%0d_cycle", j), ev_k[j], exp_k[j]);
                check($sformatf("hold18_ev%0d_rep",   j), ev_r[j], exp_r[j]);
            end
        end
        check("hold18_release_count", n_rel, 1);
        check("hold18_held_after",    held,  0);
        check("hold18_drop",          drop,  0);

        // Same hold, never acked: press stays latched, three repeats dropped.
        do_reset(1'b0);
        tick();
        bad = 0;
        for (int k = 0; k < 18; k++) begin
            deb = 1'b1;
            tick();
            if (valid !== 1'b1 || rep !== 1'b0) bad++;
            if (k == 8) check("noack_drop_at_8", drop, 1);
        end
        check("noack_payload_stable", bad, 0);
        check("noack_drop", drop, 3);
        deb = 1'b0;
        tick();
        check("noack_valid_after_release", valid, 1);
        // Reset mid-operation discards the pending event and the drop count.
        do_reset(1'b0);
        check("midreset_valid", valid, 0);
        check("midreset_drop",  drop,  0);
        check("midreset_held",  held,  0);

        // Button held through reset: no event until released and pressed again.
        do_reset(1'b1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            deb = 1'b1;
            tick();
            if (valid !== 1'b0 || held !== 1'b0) bad++;
        end
        check("held_through_reset_quiet", bad, 0);
        deb = 1'b0;
        tick();
        tick();
        check("held_through_reset_idle", valid, 0);
        deb = 1'b1;
        tick();
        check("repress_valid", valid, 1);
        check("repress_rep",   rep,   0);
        check("repress_held",  held,  1);

        // Ack coincides with the first repeat: payload replaced, nothing dropped.
        do_reset(1'b0);
        tick();
        deb = 1'b1;
        tick();
        check("coinc_press_valid", valid, 1);
        for (int k = 1; k < 8; k++) tick();
        check("coinc_pre_rep", rep, 0);
        ack = 1'b1;
        tick();
        check("coinc_valid", valid, 1);
        check("coinc_rep",   rep,   1);
        check("coinc_drop",  drop,  0);
        tick();
        check("coinc_acked_valid", valid, 0);
        ack = 1'b0;
        deb = 1'b0;
        tick();

        // Repeat disabled: one event across a 30-cycle hold.
        do_reset(1'b0);
        tick();
        n_ev  = 0;
        n_rel = 0;
        bad   = 0;
        for (int k = 0; k < 32; k++) begin
            deb = (k < 30);
            ack = nr_valid;
            tick();
            if (nr_valid) n_ev++;
            if (nr_rel) n_rel++;
            if (k < 30 && nr_held !== 1'b1) bad++;
        end
        ack = 1'b0;
        check("norepeat_event_count", n_ev, 1);
        check("norepeat_held",        bad,  0);
        check("norepeat_release",     n_rel, 1);
        check("norepeat_drop",        nr_drop, 0);

        // Long unacked hold: drop counter saturates at 255.
        do_reset(1'b0);
        tick();
        for (int k = 0; k < 1100; k++) begin
            deb = 1'b1;
            tick();
        end
        check("drop_saturate", drop, 255);
        check("drop_sat_payload", rep, 0);
        deb = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
